// File: rtl/kgp_wide_add_seq_if.sv
// Operand, adder-slice and result signals of the wide KGP add sequencer.
// out_ovf exists only when KGP_OVF_CHECK_EN is defined.
interface kgp_wide_add_seq_if #(
    parameter int unsigned WORDS = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   in_a;
    logic [16*WORDS-1:0]   in_b;
    logic                  in_cin;

    logic [15:0]           add_a;
    logic [15:0]           add_b;
    logic                  add_cin;
    logic [16:0]           add_y;

    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
`ifdef KGP_OVF_CHECK_EN
    logic                  out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, add_y, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_y, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, add_y, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_y, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/kgp_wide_add_seq.sv
// Widens a 16-bit combinational KGP adder to 16*WORDS bits by walking one slice per cycle.
// Optional overflow flag on out_ovf when KGP_OVF_CHECK_EN is defined.
module kgp_wide_add_seq #(
    parameter int unsigned WORDS = 2
) (
    input logic              clk,
    input logic              rst_n,
    kgp_wide_add_seq_if.slave bus
);
    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;
    logic            accept;
    logic            last_slice;
`ifdef KGP_OVF_CHECK_EN
    logic            ovf_q;
`endif

    assign accept     = bus.in_valid && (state_q == StIdle);
    assign last_slice = (state_q == StRun) && (idx_q == LastIdx);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid)  state_d = StRun;
            StRun:   if (idx_q == LastIdx) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode; adder inputs are forced to zero outside RUN and results only leave in DONE
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        bus.add_cin   = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
`ifdef KGP_OVF_CHECK_EN
        bus.out_ovf   = 1'b0;
`endif
        unique case (state_q)
            StIdle: bus.in_ready = 1'b1;
            StRun: begin
                bus.add_a   = a_q[16*idx_q +: 16];
                bus.add_b   = b_q[16*idx_q +: 16];
                bus.add_cin = carry_q;
            end
            StDone: begin
                bus.out_valid = 1'b1;
                bus.out_sum   = sum_q;
                bus.out_cout  = carry_q;
`ifdef KGP_OVF_CHECK_EN
                bus.out_ovf   = ovf_q;
`endif
            end
            default: ;
        endcase
    end

    // Operand capture and slice-by-slice accumulation, carry chained through carry_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            sum_q   <= '0;
            carry_q <= bus.in_cin;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            sum_q[16*idx_q +: 16] <= bus.add_y[15:0];
            carry_q               <= bus.add_y[16];
            if (idx_q != LastIdx) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef KGP_OVF_CHECK_EN
    // Signed overflow: like-signed operands whose top result bit differs from their sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last_slice) begin
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (bus.add_y[15] != a_q[W-1]);
        end
    end
`else
    logic unused_last_slice;
    assign unused_last_slice = last_slice;
`endif

endmodule

// File: tb/tb_kgp_wide_add_seq.sv
// Directed self-checking bench for kgp_wide_add_seq with WORDS=2 and a behavioural 16-bit adder.
module tb_kgp_wide_add_seq;
    localparam int unsigned WORDS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    logic [31:0] st_a [3] = '{32'h0000_0001, 32'hFFFF_0000, 32'h8000_8000};
    logic [31:0] st_b [3] = '{32'h0000_0002, 32'h0001_0000, 32'h8000_8000};
    logic        st_c [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] st_s [3] = '{32'h0000_0003, 32'h0000_0000, 32'h0001_0001};
    logic        st_o [3] = '{1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    kgp_wide_add_seq_if #(.WORDS(WORDS)) bus ();

    kgp_wide_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 16-bit KGP adder stand-in
    assign bus.add_y = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts clock edges from accept until out_valid is seen; bounded
    task automatic wait_done(output int l);
        l = 0;
        @(negedge clk);
        while (!bus.out_valid && l < 10) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] es, input logic ec);
        start_op(a, b, cin);
        wait_done(lat);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_sum"}, bus.out_sum, es);
        check({tag, "_cout"}, bus.out_cout, ec);
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        check({tag, "_vld_clr"}, bus.out_valid, 0);
        check({tag, "_rdy"}, bus.in_ready, 1);
    endtask

    initial begin
        int n;
        int got;
        int last_cyc;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #22;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_cout", bus.out_cout, 0);
        check("rst_add_a", bus.add_a, 0);
        check("rst_add_cin", bus.add_cin, 0);
`ifdef KGP_OVF_CHECK_EN
        check("rst_out_ovf", bus.out_ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Slice carry chaining
        start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        check("chain_s0_add_a", bus.add_a, 16'hFFFF);
        check("chain_s0_add_cin", bus.add_cin, 0);
        @(negedge clk);
        check("chain_s1_add_a", bus.add_a, 16'h0000);
        check("chain_s1_add_cin", bus.add_cin, 1);
        check("chain_s1_vld", bus.out_valid, 0);
        @(negedge clk);
        check("chain_vld", bus.out_valid, 1);
        check("chain_sum", bus.out_sum, 32'h0001_0000);
        check("chain_cout", bus.out_cout, 0);
        finish_op("chain");

        // All ones with carry-in
        run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        finish_op("ones");

        // Backpressure; in_valid with new operands must be ignored
        bus.out_ready = 1'b0;
        run_op("bp", 32'h0001_0002, 32'h0003_0004, 1'b0, 32'h0004_0006, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'hDEAD_BEEF;
            bus.in_b     = 32'h1111_1111;
            @(negedge clk);
            check("bp_hold_vld", bus.out_valid, 1);
            check("bp_hold_sum", bus.out_sum, 32'h0004_0006);
            check("bp_hold_rdy", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        finish_op("bp");

        // Reset during RUN
        start_op(32'hAAAA_5555, 32'h1111_1111, 1'b0);
        @(negedge clk);
        check("rr_run_add_a", bus.add_a, 16'h5555);
        rst_n = 1'b0;
        #1;
        check("rr_vld", bus.out_valid, 0);
        check("rr_add_a", bus.add_a, 0);
        check("rr_rdy", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("rr_fresh", 32'h0000_1234, 32'h0000_5678, 1'b0, 32'h0000_68AC, 1'b0);
        finish_op("rr_fresh");

`ifdef KGP_OVF_CHECK_EN
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
        check("ovf_pos_flag", bus.out_ovf, 1);
        finish_op("ovf_pos");
        run_op("ovf_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        check("ovf_neg_flag", bus.out_ovf, 0);
        finish_op("ovf_neg");
`endif

        // Streaming with in_valid and out_ready held high
        n        = 0;
        got      = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                check("stream_sum", bus.out_sum, st_s[got]);
                check("stream_cout", bus.out_cout, st_o[got]);
                if (got > 0) check("stream_gap", cyc - last_cyc, 4);
                last_cyc = cyc;
                got++;
            end
            if (bus.in_ready) begin
                if (n < 3) begin
                    bus.in_a     = st_a[n];
                    bus.in_b     = st_b[n];
                    bus.in_cin   = st_c[n];
                    bus.in_valid = 1'b1;
                    n++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        check("stream_count", got, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kgp_wide_add_seq.md
# kgp_wide_add_seq

Multi-cycle sequencer that widens the 16-bit KGP (kill/generate/propagate) adder to 16×WORDS-bit operands. It sits directly upstream of the 16-bit KGP adder and also captures the adder's result. Each cycle it feeds one 16-bit slice pair plus a carry into the adder, then registers the adder's 17-bit result, chaining y[16] into the next slice. A valid/ready handshake is used on both the operand side and the result side.

## Interface
Parameters:
- WORDS, default 2: number of 16-bit slices. Must be ≥ 1.

Ports:
- clk  input  1  clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block can accept operands. High only in IDLE.
- in_a  input  16*WORDS  operand A.
- in_b  input  16*WORDS  operand B.
- in_cin  input  1  carry-in.
- add_a  output  16  slice of A driven to the KGP adder input a.
- add_b  output  16  slice of B driven to the KGP adder input b.
- add_cin  output  1  carry driven to the KGP adder input cin.
- add_y  input  17  KGP adder result y. Bit 16 is carry-out. Combinational from add_a/add_b/add_cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  16*WORDS  sum.
- out_cout  output  1  final carry-out.
- out_ovf  output  1  two's-complement overflow. Present only with KGP_OVF_CHECK_EN.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: slice index idx counts 0..WORDS-1.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&&in_ready. On that edge:
  - register in_a, in_b;
  - carry_r ← in_cin;
  - idx ← 0;
  - clear the sum register.
- RUN, combinational outputs:
  - add_a = a_r[16*idx +: 16];
  - add_b = b_r[16*idx +: 16];
  - add_cin = carry_r.
- RUN, each clock edge:
  - sum_r[16*idx +: 16] ← add_y[15:0];
  - carry_r ← add_y[16];
  - idx ← idx+1.
  - If idx==WORDS-1, go to DONE instead.
- DONE:
  - out_sum = sum_r; out_cout = carry_r; both held stable.
  - DONE→IDLE on out_valid&&out_ready.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, computed modulo 2^(16*WORDS+1). The result is exact; no truncation.
- Any in_valid outside IDLE is ignored, because in_ready=0. The operand registers are not disturbed.
- WORDS=1: RUN lasts exactly one cycle.
- idx width is max(1, $clog2(WORDS)).

## Timing
- Reset (asynchronous assert, synchronous release), values held:
  - state=IDLE; in_ready=1;
  - out_valid=0; out_sum=0; out_cout=0; out_ovf=0;
  - add_a=0; add_b=0; add_cin=0;
  - idx=0; carry_r=0.
- Latency: out_valid rises WORDS cycles after the accepting edge.
- Throughput, with out_ready held high and in_valid held high: one operation every WORDS+2 cycles. The +2 covers the DONE handshake cycle and the IDLE accept cycle.
- add_y is sampled in the same cycle its slice is driven. The adder is purely combinational and must close timing within one clk period.
- Backpressure: DONE persists indefinitely while out_ready=0. out_sum, out_cout and out_ovf do not change.
- Reset mid-RUN or mid-DONE: the operation is abandoned and all outputs return to reset values immediately. No partial result is ever presented.
- in_ready is decoded from state; it has no combinational path from out_ready.

## Configuration
- KGP_OVF_CHECK_EN defined:
  - out_ovf exists.
  - It is registered at the final RUN edge as (a_msb==b_msb) && (add_y[15]!=a_msb), where a_msb and b_msb are bit 16*WORDS-1 of the operands.
  - It is valid with out_valid and held in DONE.
- KGP_OVF_CHECK_EN undefined: the out_ovf port and its logic are absent. All other behaviour is identical.

## Test plan
All cases use WORDS=2.
- Slice carry chaining: in_a=0x0000FFFF, in_b=0x00000001, in_cin=0 → out_sum=0x00010000, out_cout=0. out_valid is asserted exactly 2 cycles after accept. add_cin=1 during the second RUN cycle.
- All-ones with carry-in: in_a=0xFFFFFFFF, in_b=0xFFFFFFFF, in_cin=1 → out_sum=0xFFFFFFFF, out_cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid stays 1 and out_sum stays stable. in_ready stays 0 and a new in_valid is ignored. The handshake completes on the first cycle out_ready=1.
- Reset during RUN: pulse rst_n low one cycle after accept → out_valid=0, add_a=0, in_ready=1. A fresh 0x1234 + 0x5678 operation then yields 0x000068AC.
- Overflow, with KGP_OVF_CHECK_EN defined:
  - in_a=0x7FFFFFFF, in_b=0x00000001, in_cin=0 → out_sum=0x80000000, out_ovf=1.
  - in_a=0xFFFFFFFF, in_b=0x00000001 → out_ovf=0, out_cout=1.
- Streaming: in_valid and out_ready held high, three operand sets → results in order, one out_valid pulse every 4 cycles.
